qysys_test_nios2_qsys_0_oci_dct_sequencer: RTL and testbench
============================================================

// Module: qysys_test_nios2_qsys_0_oci_dct_sequencer
// PURPOSE
//  Sequencer for the Nios II OCI direct-conditional-trace (DCT) buffer. Packs 2-bit
//  branch codes from the CPU trace port into a 30-bit buffer with a 4-bit fill count.
//  Emits the packed word to the trace memory over a valid/ready handshake, on full,
//  on flush, or at end of test. Sits between the CPU trace tap and the OCI trace RAM
//  writer; its dct_buffer/dct_count outputs feed the OCI test bench monitor.
// PARAMETERS
//  CODE_W  2   width of one trace code
//  DEPTH   15  codes per buffer; DEPTH*CODE_W = 30
//  CNT_W   4   width of dct_count; must hold DEPTH
// PORTS
//  clk             in   1   system clock, all logic rising-edge
//  reset_n         in   1   asynchronous active-low reset
//  trace_en        in   1   codes accepted only while 1
//  code_valid      in   1   code_in is valid this cycle (no backpressure to CPU)
//  code_in         in   2   branch code
//  flush           in   1   1-cycle pulse: emit partial buffer
//  test_ending     in   1   level: end of test, forces flush, blocks new codes
//  word_ready      in   1   trace RAM writer accepts word_data
//  dct_buffer      out  30  live packing buffer
//  dct_count       out  4   codes in dct_buffer (0..DEPTH)
//  word_valid      out  1   word_data holds an unsent word
//  word_data       out  34  {count[3:0], buffer[29:0]} snapshot
//  overflow        out  1   sticky: a code was dropped
//  test_has_ended  out  1   drain complete after test_ending
// BEHAVIOUR
//  Reset (async, any state): dct_buffer=0, dct_count=0, word_valid=0, word_data=0,
//   overflow=0, test_has_ended=0, flush_pend=0.
//  Accept: code_valid & trace_en & ~test_ending & (dct_count<DEPTH or transfer this
//   cycle). Buffer shifts left by CODE_W, new code into [1:0], count+1.
//  Drop: code_valid & trace_en & ~test_ending, buffer full, no transfer -> code lost,
//   overflow<=1 (cleared only by reset).
//  flush_pend set by flush or test_ending while count>0; cleared on transfer.
//   flush with count==0 is ignored (no empty word ever emitted).
//  Transfer condition T = (count==DEPTH | flush_pend) & count>0 &
//   (~word_valid | word_ready). On T: word_data<={count,buffer}, word_valid<=1,
//   buffer/count cleared; a code accepted in the same cycle lands in the cleared
//   buffer (count=1, buffer=code). Reaching DEPTH does not transfer same cycle;
//   earliest transfer is the next edge (1-cycle latency full->word_valid).
//  Handshake: word_valid held, word_data stable until word_valid&word_ready; then
//   word_valid<=0 unless a new T occurs that cycle (back-to-back allowed).
//  States: FILL (normal), DRAIN (test_ending seen), DONE.
//   FILL->DRAIN when test_ending=1. DRAIN->DONE when count==0 & ~word_valid.
//   DONE: test_has_ended=1, stays until reset; codes ignored (no overflow set).
//   test_ending deasserting in DRAIN does not return to FILL.
//  Widths: count saturates at DEPTH by construction; no wrap.
// TESTING
//  Reset: drive reset_n=0 mid-fill (count=7, word_valid=1) -> all outputs 0 next
//   sample, no word emitted after release.
//  Full: 15 codes of 2'b10, word_ready=1 -> 1 cycle after 15th, word_valid=1,
//   word_data={4'hF,30'h2AAAAAAA}; dct_count=0.
//  Flush: 3 codes 01,10,11 then flush -> word_data={4'd3,30'h1B}; flush at count 0
//   -> no word_valid.
//  Backpressure: word_ready=0, fill 15 + 2 more codes -> overflow=1, count stays 15;
//   raise word_ready -> first word handed off, second buffer transfers next edge.
//  Simultaneous: code arrives on the transfer edge -> word has old 15 codes,
//   dct_count=1 holding new code.
//  End: 5 codes, assert test_ending, word_ready=1 -> count-5 word emitted, then
//   test_has_ended=1; later codes ignored, overflow stays 0.

Source files
------------

// File: rtl/qysys_test_nios2_qsys_0_oci_dct_sequencer.sv
// Packs 2-bit DCT branch codes into a 15-code buffer and hands full/flushed words to the trace RAM.
// Latency: buffer reaching DEPTH (or a registered flush) -> word_valid on the following edge.
// Backpressure: word_ready low holds word_valid/word_data; the CPU side is never stalled, so codes are dropped (sticky overflow).
//
// Ports:
//   clk, reset_n              rising-edge clock, asynchronous active-low reset
//   trace_en, code_valid,
//   code_in                   trace tap; a code is taken only while trace_en=1
//   flush                     1-cycle pulse, emit the partial buffer (ignored when empty)
//   test_ending               level, forces a final flush and blocks new codes
//   word_ready                trace RAM writer accepts word_data
//   dct_buffer, dct_count     live packing buffer and its fill count
//   word_valid, word_data     outgoing word {count, buffer}, held until accepted
//   overflow                  sticky, a code was lost while the buffer was full
//   test_has_ended            drain after test_ending is complete
module qysys_test_nios2_qsys_0_oci_dct_sequencer #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            trace_en,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code_in,
  input  logic                            flush,
  input  logic                            test_ending,
  input  logic                            word_ready,
  output logic [DEPTH*CODE_W-1:0]         dct_buffer,
  output logic [CNT_W-1:0]                dct_count,
  output logic                            word_valid,
  output logic [CNT_W+DEPTH*CODE_W-1:0]   word_data,
  output logic                            overflow,
  output logic                            test_has_ended
);

  localparam int BUF_W = DEPTH * CODE_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Outgoing word: fill count in the top bits, packed codes below.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] codes;
  } dct_word_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buffer_q;
  logic [CNT_W-1:0] count_q;
  dct_word_t        word_q;
  logic             word_vld_q;
  logic             flush_pend_q;
  logic             overflow_q;

  logic code_try;
  logic is_full;
  logic not_empty;
  logic xfer;
  logic accept;
  logic drop;

  // Datapath decode. A transfer empties the buffer on the same edge, which is
  // what lets a code arriving on a full buffer still be accepted when the
  // outgoing slot is free or being drained this cycle.
  always_comb begin
    code_try  = 1'b0;
    is_full   = 1'b0;
    not_empty = 1'b0;
    xfer      = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;

    // Codes are only taken in FILL; after test_ending they are ignored
    // outright and never count as overflow.
    code_try  = code_valid & trace_en & ~test_ending & (state_q == FILL);
    is_full   = (count_q == DEPTH_C);
    not_empty = (count_q != '0);
    xfer      = (is_full | flush_pend_q) & not_empty & (~word_vld_q | word_ready);
    accept    = code_try & (~is_full | xfer);
    drop      = code_try & is_full & ~xfer;
  end

  // Phase control: once test_ending is seen we never go back to FILL, even
  // if test_ending later drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (test_ending) state_d = DRAIN;
      DRAIN:   if (!not_empty && !word_vld_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Packing buffer and fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer_q <= '0;
      count_q  <= '0;
    end else if (xfer) begin
      // Old contents leave in word_q; a same-cycle code starts the new buffer.
      buffer_q <= accept ? BUF_W'(code_in) : '0;
      count_q  <= accept ? ONE_C : '0;
    end else if (accept) begin
      buffer_q <= {buffer_q[BUF_W-CODE_W-1:0], code_in};
      count_q  <= count_q + ONE_C;
    end
  end

  // Output word register: a new transfer may overwrite a word in the same
  // cycle it is being accepted, giving back-to-back words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else if (xfer) begin
      word_q     <= {count_q, buffer_q};
      word_vld_q <= 1'b1;
    end else if (word_vld_q && word_ready) begin
      word_vld_q <= 1'b0;
    end
  end

  // Pending flush request. An empty buffer never raises it, so no empty word
  // is emitted. DRAIN keeps it asserted in case test_ending was only brief.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend_q <= 1'b0;
    end else if (xfer) begin
      flush_pend_q <= 1'b0;
    end else if ((flush || test_ending || (state_q == DRAIN)) && not_empty) begin
      flush_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign dct_buffer     = buffer_q;
  assign dct_count      = count_q;
  assign word_valid     = word_vld_q;
  assign word_data      = word_q;
  assign overflow       = overflow_q;
  assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_qysys_test_nios2_qsys_0_oci_dct_sequencer.sv
module tb_qysys_test_nios2_qsys_0_oci_dct_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_en;
  logic        code_valid;
  logic [1:0]  code_in;
  logic        flush;
  logic        test_ending;
  logic        word_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [33:0] word_data;
  logic        overflow;
  logic        test_has_ended;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] exp_q[$];

  qysys_test_nios2_qsys_0_oci_dct_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_en       (trace_en),
    .code_valid     (code_valid),
    .code_in        (code_in),
    .flush          (flush),
    .test_ending    (test_ending),
    .word_ready     (word_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] c);
    trace_en   = 1'b1;
    code_valid = 1'b1;
    code_in    = c;
    cyc();
    code_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_buffer"},   34'(dct_buffer), 34'd0);
    check({tag, "_count"},    34'(dct_count), 34'd0);
    check({tag, "_valid"},    34'(word_valid), 34'd0);
    check({tag, "_data"},     word_data, 34'd0);
    check({tag, "_overflow"}, 34'(overflow), 34'd0);
    check({tag, "_ended"},    34'(test_has_ended), 34'd0);
  endtask

  // Scoreboard monitor: every accepted word is compared against the next
  // expected word; a word with nothing expected is itself a failure.
  task automatic monitor();
    logic [33:0] exp;
    forever begin
      @(negedge clk);
      if (reset_n && word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", word_data);
        end else begin
          exp = exp_q.pop_front();
          check("word_data", word_data, exp);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    trace_en    = 1'b0;
    code_valid  = 1'b0;
    code_in     = 2'b00;
    flush       = 1'b0;
    test_ending = 1'b0;
    word_ready  = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) cyc();
    check_zero("reset");
    reset_n = 1'b1;
    cyc();

    // Full buffer: 15 x 2'b10, one cycle to the word.
    word_ready = 1'b1;
    repeat (15) send(2'b10);
    check("full_count", 34'(dct_count), 34'd15);
    check("full_no_early_valid", 34'(word_valid), 34'd0);
    exp_q.push_back({4'hF, 30'h2AAAAAAA});
    cyc();
    check("full_valid", 34'(word_valid), 34'd1);
    check("full_count_cleared", 34'(dct_count), 34'd0);
    cyc();
    check("full_valid_drop", 34'(word_valid), 34'd0);

    // Flush of a partial buffer, then a flush on an empty buffer.
    send(2'b01);
    send(2'b10);
    send(2'b11);
    check("flush_buffer", 34'(dct_buffer), 34'h1B);
    check("flush_count", 34'(dct_count), 34'd3);
    exp_q.push_back({4'd3, 30'h1B});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_pending", 34'(word_valid), 34'd0);
    cyc();
    check("flush_valid", 34'(word_valid), 34'd1);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
    check("empty_flush_no_word", 34'(word_valid), 34'd0);

    // Backpressure: two buffers of codes, then two dropped codes.
    word_ready = 1'b0;
    repeat (15) send(2'b01);
    repeat (15) send(2'b11);
    exp_q.push_back({4'hF, 30'h15555555});
    exp_q.push_back({4'hF, 30'h3FFFFFFF});
    check("bp_valid_held", 34'(word_valid), 34'd1);
    check("bp_no_overflow_yet", 34'(overflow), 34'd0);
    send(2'b00);
    send(2'b00);
    check("bp_overflow", 34'(overflow), 34'd1);
    check("bp_count_stays", 34'(dct_count), 34'd15);
    check("bp_buffer_kept", 34'(dct_buffer), 34'h3FFFFFFF);
    check("bp_data_stable", word_data, {4'hF, 30'h15555555});
    word_ready = 1'b1;
    cyc();
    check("bp_back_to_back_valid", 34'(word_valid), 34'd1);
    check("bp_count_cleared", 34'(dct_count), 34'd0);
    cyc();
    check("bp_drained", 34'(word_valid), 34'd0);

    // Code arriving on the transfer edge starts the next buffer.
    repeat (15) send(2'b10);
    exp_q.push_back({4'hF, 30'h2AAAAAAA});
    send(2'b11);
    check("simul_count", 34'(dct_count), 34'd1);
    check("simul_buffer", 34'(dct_buffer), 34'h3);
    check("simul_valid", 34'(word_valid), 34'd1);
    cyc();

    // Reset mid-fill with a word pending: nothing may come out afterwards.
    word_ready = 1'b0;
    repeat (15) send(2'b10);
    cyc();
    check("rst_pre_valid", 34'(word_valid), 34'd1);
    repeat (6) send(2'b01);
    check("rst_pre_count", 34'(dct_count), 34'd7);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    cyc();
    reset_n    = 1'b1;
    word_ready = 1'b1;
    repeat (3) cyc();
    check("rst_no_word", 34'(word_valid), 34'd0);

    // End of test: partial word drained, then DONE ignores codes.
    send(2'b01);
    send(2'b10);
    send(2'b11);
    send(2'b00);
    send(2'b01);
    check("end_buffer", 34'(dct_buffer), 34'h1B1);
    check("end_count", 34'(dct_count), 34'd5);
    exp_q.push_back({4'd5, 30'h1B1});
    test_ending = 1'b1;
    cyc();
    check("end_not_done_early", 34'(test_has_ended), 34'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (test_has_ended) break;
    end
    check("end_test_has_ended", 34'(test_has_ended), 34'd1);
    test_ending = 1'b0;
    repeat (4) send(2'b10);
    check("done_count", 34'(dct_count), 34'd0);
    check("done_overflow", 34'(overflow), 34'd0);
    check("done_sticky", 34'(test_has_ended), 34'd1);
    check("done_no_word", 34'(word_valid), 34'd0);
    check("scoreboard_empty", 34'(exp_q.size()), 34'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
